// File: rtl/keypad_matrix_scan_if.sv
// Keypad scanner signal bundle: column sense in, row drive and debounced key code out.
interface keypad_matrix_scan_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_press;
  logic        key_release;

  modport master (output col_in, input row_out, onehot, key_press, key_release);
  modport slave  (input col_in, output row_out, onehot, key_press, key_release);
endinterface

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner: row sequencing, per-frame multi-key rejection,
// frame-count debounce and one-cycle press/release pulses.
module keypad_matrix_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_matrix_scan_if.slave kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row;
  logic [1:0]       row_next;
  logic [11:0]      frame;
  logic [15:0]      frame_full;
  logic [15:0]      frame_val;
  logic [15:0]      cand;
  logic [15:0]      cand_next;
  logic [15:0]      onehot_q;
  logic [STB_W-1:0] stable;
  logic [STB_W-1:0] stable_next;
  logic             slot_end;

  // Row 3 is never stored: its columns are merged straight into the completed frame.
  always_comb begin
    slot_end   = (div_cnt == DIV_LAST);
    row_next   = row + 2'd1;
    frame_full = {~kp.col_in, frame};
    frame_val  = ($countones(frame_full) == 1) ? frame_full : 16'h0000;
    if (frame_val != cand) begin
      cand_next   = frame_val;
      stable_next = STB_W'(1);
    end else begin
      cand_next   = cand;
      stable_next = (stable == STB_MAX) ? stable : stable + STB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt        <= '0;
      row            <= 2'd0;
      frame          <= '0;
      cand           <= '0;
      stable         <= '0;
      onehot_q       <= '0;
      kp.row_out     <= 4'b1110;
      kp.onehot      <= '0;
      kp.key_press   <= 1'b0;
      kp.key_release <= 1'b0;
    end else begin
      // Pulses trail the onehot update by one cycle.
      kp.key_press   <= (kp.onehot != onehot_q) && (kp.onehot != 16'h0000);
      kp.key_release <= (kp.onehot != onehot_q) && (kp.onehot == 16'h0000);
      onehot_q       <= kp.onehot;

      if (slot_end) begin
        div_cnt    <= '0;
        row        <= row_next;
        kp.row_out <= ~(4'b0001 << row_next);
        case (row)
          2'd0: frame[3:0]  <= ~kp.col_in;
          2'd1: frame[7:4]  <= ~kp.col_in;
          2'd2: frame[11:8] <= ~kp.col_in;
          default: begin
            frame  <= '0;
            cand   <= cand_next;
            stable <= stable_next;
            if (stable_next == STB_MAX && cand_next != kp.onehot)
              kp.onehot <= cand_next;
          end
        endcase
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end
endmodule
